// File: rtl/alu_issue_ctrl_if.sv
// Request/response and ALU-side signals of the ALU issue controller.
// The master modport is the requester/ALU environment; the slave modport is the controller.
interface alu_issue_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_rs;
  logic [7:0] req_rt;
  logic [7:0] alu_rs;
  logic [7:0] alu_rt;
  logic [1:0] alu_op;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_dz;

  modport master (
    output req_valid, req_op, req_rs, req_rt, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, rsp_dz, alu_rs, alu_rt, alu_op
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, rsp_dz, alu_rs, alu_rt, alu_op
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-outstanding issue controller for a combinational 8-bit ALU (IDLE -> EXEC -> RESP).
// Optional macro ALU_ISSUE_DIV_ZERO_CHECK_EN: divide by zero bypasses EXEC with 8'hFF and rsp_dz=1.
module alu_issue_ctrl #(
  parameter int ADDSUB_CYCLES = 1,
  parameter int MUL_CYCLES    = 2,
  parameter int DIV_CYCLES    = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_ctrl_if.slave bus,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // req_ready is high only in IDLE; rsp_valid is high only in RESP and holds data until rsp_ready.
  assign accept    = bus.req_valid & bus.req_ready;
  assign dbg_state = state;

  function automatic logic [3:0] exec_load(input logic [1:0] op);
    logic [3:0] v;
    case (op)
      2'b10:   v = 4'(MUL_CYCLES - 1);
      2'b11:   v = 4'(DIV_CYCLES - 1);
      default: v = 4'(ADDSUB_CYCLES - 1);
    endcase
    return v;
  endfunction

`ifdef ALU_ISSUE_DIV_ZERO_CHECK_EN
  logic div_zero;
  assign div_zero = (bus.req_op == 2'b11) && (bus.req_rt == 8'd0);
`else
  logic div_zero;
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.alu_rs    <= 8'd0;
      bus.alu_rt    <= 8'd0;
      bus.alu_op    <= 2'b00;
      bus.rsp_data  <= 8'd0;
      bus.rsp_valid <= 1'b0;
      bus.req_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept) begin
            bus.alu_rs    <= bus.req_rs;
            bus.alu_rt    <= bus.req_rt;
            bus.alu_op    <= bus.req_op;
            cnt           <= exec_load(bus.req_op);
            bus.req_ready <= 1'b0;
            if (div_zero) begin
              bus.rsp_data  <= 8'hFF;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.rsp_data  <= bus.alu_out;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE raises req_ready for the next cycle, so no accept overlaps the response.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_DIV_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_dz <= 1'b0;
    end else if (state == IDLE && accept) begin
      bus.rsp_dz <= div_zero;
    end
  end
`else
  assign bus.rsp_dz = 1'b0;
`endif

endmodule
